// File: rtl/seq_defs.sv
// Shared definitions for the sequence checker and counter source.
// State encodings and default data width.
package seq_defs;

  localparam int SEQ_WIDTH = 8;

  typedef enum logic [1:0] {
    SEQ_HUNT    = 2'd0,
    SEQ_ACQUIRE = 2'd1,
    SEQ_LOCKED  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_checker_if.sv
// Sample stream into the checker plus its status outputs.
// master is the sample source, slave is the checker.
interface seq_checker_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 16
);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0]     expected;

  modport master (
    output in_valid,
    output in_data,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  expected
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output locked,
    output err_pulse,
    output err_count,
    output expected
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with sync clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Locks onto a mod-2^WIDTH incrementing stream and
// flags/counts every sample that breaks it once locked.
module seq_checker
  import seq_defs::*;
#(
  parameter int WIDTH      = SEQ_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_WIDTH  = 16
) (
  input logic          clk,
  input logic          rst,
  seq_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_N = LW'(LOSS_COUNT);

  seq_state_t           state;
  logic [WIDTH-1:0]     expected;
  logic [MW-1:0]        match_cnt;
  logic [LW-1:0]        miss_cnt;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_q;

  logic             hit;
  logic [WIDTH-1:0] nxt_data;
  logic [WIDTH-1:0] nxt_exp;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;
  logic             err_inc;

  assign hit       = bus.in_data == expected;
  assign nxt_data  = bus.in_data + WIDTH'(1);
  assign nxt_exp   = expected + WIDTH'(1);
  assign match_inc = match_cnt + MW'(1);
  assign miss_inc  = miss_cnt + LW'(1);
  assign err_inc   = bus.in_valid && (state == SEQ_LOCKED) && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEQ_HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.in_valid) begin
        unique case (1'b1)
          (state == SEQ_HUNT): begin
            expected  <= nxt_data;
            match_cnt <= '0;
            state     <= SEQ_ACQUIRE;
          end
          (state == SEQ_ACQUIRE): begin
            if (hit) begin
              expected  <= nxt_exp;
              match_cnt <= match_inc;
              if (match_inc == LOCK_N) begin
                state    <= SEQ_LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              expected  <= nxt_data;
              match_cnt <= '0;
            end
          end
          (state == SEQ_LOCKED): begin
            if (hit) begin
              expected <= nxt_exp;
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              miss_cnt  <= miss_inc;
              // Free-wheel on isolated misses; realign only on loss.
              if (miss_inc == LOSS_N) begin
                state     <= SEQ_ACQUIRE;
                locked    <= 1'b0;
                expected  <= nxt_data;
                match_cnt <= '0;
              end else begin
                expected <= nxt_exp;
              end
            end
          end
          default: begin
            state  <= SEQ_HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W (ERR_WIDTH)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (err_inc),
    .q   (err_q)
  );

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_q;
  assign bus.expected  = expected;

endmodule
